// File: rtl/tiny_dnn_pkg.sv
// Shared widths and state encoding for the result-streaming blocks.
package tiny_dnn_pkg;
    localparam int DW = 32;
    localparam int AW = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } osc_state_e;
endpackage

// File: rtl/out_stream_ctrl_if.sv
// Valid/ready output stream carrying result words with an end-of-burst marker.
interface out_stream_ctrl_if #(
    parameter int DW = tiny_dnn_pkg::DW
);
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/out_fifo2.sv
// Two-entry FIFO of (data, last) pairs; the head entry feeds the stream directly from flops.
module out_fifo2 #(
    parameter int DW = tiny_dnn_pkg::DW
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic [1:0]    count
);
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop_ok;
    logic [1:0][DW-1:0] ent_data;
    logic [1:0]        ent_last;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DW-1:0] data_q, data_d;
            logic          last_q, last_d;

            always_comb begin
                data_d = data_q;
                last_d = last_q;
                if (push && (wr_ptr_q == 1'(gi))) begin
                    data_d = push_data;
                    last_d = push_last;
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    data_q <= '0;
                    last_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    last_q <= last_d;
                end
            end

            assign ent_data[gi] = data_q;
            assign ent_last[gi] = last_q;
        end
    endgenerate

    assign valid  = (count_q != 2'd0);
    assign pop_ok = pop & valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_q + {1'b0, push} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // last is qualified so it never shows a stale tag while the stream is idle
    assign head_data = ent_data[rd_ptr_q];
    assign head_last = valid & ent_last[rd_ptr_q];
    assign count     = count_q;
endmodule

// File: rtl/out_stream_ctrl.sv
// Reads ds+1 result words from memory after s_fin and streams them out with
// credit-based issue so the 2-entry FIFO can never overflow.
module out_stream_ctrl
    import tiny_dnn_pkg::*;
#(
    parameter int DW = tiny_dnn_pkg::DW,
    parameter int AW = tiny_dnn_pkg::AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                s_fin,
    input  logic [AW-1:0]       ds,
    output logic                mem_re,
    output logic [AW-1:0]       mem_a,
    input  logic [DW-1:0]       mem_d,
    output logic                busy,
    output logic                done,
    out_stream_ctrl_if.master   m
);
    osc_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ds_q, ds_d;
    logic          inflight_q, inflight_d;
    logic          infl_last_q, infl_last_d;
    logic          done_q, done_d;

    logic          clr;
    logic          issue;
    logic          pop;
    logic [1:0]    load;
    logic          fifo_valid;
    logic          fifo_last;
    logic [1:0]    fifo_cnt;
    logic [DW-1:0] fifo_data;

    assign clr  = reset | ~run;
    assign pop  = fifo_valid & m.m_ready;
    // occupancy the FIFO will have once this cycle's return and pop settle
    assign load = fifo_cnt + {1'b0, inflight_q} - {1'b0, pop};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ds_d        = ds_q;
        inflight_d  = 1'b0;
        infl_last_d = 1'b0;
        done_d      = 1'b0;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_fin) begin
                    ds_d    = ds;
                    cnt_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!clr && (load < 2'd2)) begin
                    issue       = 1'b1;
                    inflight_d  = 1'b1;
                    infl_last_d = (cnt_q == ds_q);
                    if (cnt_q == ds_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ds_q        <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ds_q        <= ds_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

    out_fifo2 #(.DW(DW)) u_fifo (
        .clk       (clk),
        .srst      (clr),
        .push      (inflight_q),
        .push_data (mem_d),
        .push_last (infl_last_q),
        .pop       (pop),
        .valid     (fifo_valid),
        .head_data (fifo_data),
        .head_last (fifo_last),
        .count     (fifo_cnt)
    );

    assign mem_re    = issue;
    assign mem_a     = cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign m.m_valid = fifo_valid;
    assign m.m_data  = fifo_data;
    assign m.m_last  = fifo_last;
endmodule
